// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 device-to-host receiver with glitch filter, frame checks, timeout and show-ahead FIFO
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH  = 8,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          nextdata_n,
    input  logic                          ovf_clr,
    output logic [7:0]                    data,
    output logic                          ready,
    output logic                          overflow,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [LW-1:0] DEPTH   = LW'(FIFO_DEPTH);
    localparam logic [FW-1:0] FLEN_M1 = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_M1  = TW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          fclk_q, fclk_d, fclk_prev_q;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [1:0]    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          perr_q, perr_d, ferr_q, ferr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    mem [FIFO_DEPTH];
    logic          sample, push, pop, full, accept, drop;

    // fclk follows the synchronised pin only after FILTER_LEN agreeing samples
    always_comb begin
        fclk_d = fclk_q;
        fcnt_d = '0;
        if (clk_s2_q != fclk_q) begin
            if (fcnt_q == FLEN_M1) fclk_d = clk_s2_q;
            else                   fcnt_d = fcnt_q + FW'(1);
        end
    end

    assign sample = fclk_prev_q & ~fclk_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tmo_d     = tmo_q;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        push      = 1'b0;
        if (state_q == S_IDLE) begin
            tmo_d = '0;
            if (sample && !dat_s2_q) begin
                bit_cnt_d = '0;
                state_d   = S_DATA;
            end
        end else if (sample) begin
            tmo_d = '0;
            if (state_q == S_DATA) begin
                shift_d   = {dat_s2_q, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) state_d = S_PARITY;
            end else if (state_q == S_PARITY) begin
                par_d   = dat_s2_q;
                state_d = S_STOP;
            end else begin
                state_d = S_IDLE;
                if (!(^{shift_q, par_q})) perr_d = 1'b1;
                else if (!dat_s2_q)       ferr_d = 1'b1;
                else                      push   = 1'b1;
            end
        end else if (tmo_q == TMO_M1) begin
            ferr_d  = 1'b1;
            tmo_d   = '0;
            state_d = S_IDLE;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted
    always_comb begin
        pop      = !nextdata_n && (level_q != '0);
        full     = (level_q == DEPTH);
        accept   = push && (!full || pop);
        drop     = push && full && !pop;
        wr_ptr_d = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (accept && !pop)      level_d = level_q + LW'(1);
        else if (!accept && pop) level_d = level_q - LW'(1);
        ovf_d = ovf_q;
        if (drop)         ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            fclk_q      <= 1'b1;
            fclk_prev_q <= 1'b1;
            fcnt_q      <= '0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            clk_s1_q    <= ps2_clk;
            clk_s2_q    <= clk_s1_q;
            dat_s1_q    <= ps2_data;
            dat_s2_q    <= dat_s1_q;
            fclk_q      <= fclk_d;
            fclk_prev_q <= fclk_q;
            fcnt_q      <= fcnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr_q] <= shift_q;
    end

    assign data       = (level_q != '0) ? mem[rd_ptr_q] : 8'h00;
    assign ready      = (level_q != '0);
    assign level      = level_q;
    assign overflow   = ovf_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - randomized self-checking bench for ps2_rx_fifo against a queue model
module tb_ps2_rx_fifo;
    localparam int DEPTH = 4;
    localparam int FL    = 4;
    localparam int TMO   = 300;
    // posedges from a raw ps2_clk fall (driven at a negedge) to the edge that acts on that sample
    localparam int PUSH_LAT = FL + 3;

    logic       clk = 1'b0, rst = 1'b0;
    logic       ps2_clk = 1'b1, ps2_data = 1'b1, nextdata_n = 1'b1, ovf_clr = 1'b0;
    logic [7:0] data;
    logic       ready, overflow, parity_err, frame_err;
    logic [2:0] level;

    int n_tests = 0, n_fail = 0;
    int perr_cnt = 0, ferr_cnt = 0;
    logic [7:0] model_q[$];
    bit model_ovf = 1'b0;

    ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FL), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .nextdata_n(nextdata_n), .ovf_clr(ovf_clr), .data(data), .ready(ready),
        .overflow(overflow), .parity_err(parity_err), .frame_err(frame_err), .level(level)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (parity_err) perr_cnt++;
        if (frame_err)  ferr_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit b);
        ps2_data = b;
        tick(4);
        ps2_clk = 1'b0;
        tick(8);
        ps2_clk = 1'b1;
        tick(4);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(stop);
        ps2_data = 1'b1;
        tick(4);
    endtask

    task automatic pop1();
        nextdata_n = 1'b0;
        tick(1);
        nextdata_n = 1'b1;
    endtask

    function automatic void model_push(input logic [7:0] b);
        if (model_q.size() < DEPTH) model_q.push_back(b);
        else model_ovf = 1'b1;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        tick(3);
        n_tests++;
        if ({data, ready, level} !== 12'h000) begin
            n_fail++; $display("FAIL reset_outputs: data/ready/level=%h expected 000", {data, ready, level});
        end
        n_tests++;
        if ({overflow, parity_err, frame_err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000", {overflow, parity_err, frame_err});
        end
        rst = 1'b1;
        tick(2);
    endtask

    task automatic test_single_byte();
        send_frame(8'h1C, 1'b0, 1'b1);
        n_tests++;
        if ({ready, data, level} !== {1'b1, 8'h1C, 3'd1}) begin
            n_fail++; $display("FAIL single_rx: ready=%b data=%h level=%0d expected 1 1c 1", ready, data, level);
        end
        pop1();
        n_tests++;
        if ({ready, data, level} !== {1'b0, 8'h00, 3'd0}) begin
            n_fail++; $display("FAIL single_pop: ready=%b data=%h level=%0d expected 0 00 0", ready, data, level);
        end
    endtask

    task automatic test_errors();
        int p0, f0;
        logic [7:0] b;
        p0 = perr_cnt; f0 = ferr_cnt;
        send_frame(8'h1C, 1'b1, 1'b1);
        n_tests++;
        if (perr_cnt - p0 != 1 || ferr_cnt != f0 || level !== 3'd0) begin
            n_fail++; $display("FAIL parity_err: perr=%0d ferr=%0d level=%0d expected 1 0 0", perr_cnt - p0, ferr_cnt - f0, level);
        end
        p0 = perr_cnt; f0 = ferr_cnt;
        b = 8'($urandom);
        send_frame(b, 1'b0, 1'b0);
        n_tests++;
        if (ferr_cnt - f0 != 1 || perr_cnt != p0 || level !== 3'd0) begin
            n_fail++; $display("FAIL stop_err: ferr=%0d perr=%0d level=%0d expected 1 0 0", ferr_cnt - f0, perr_cnt - p0, level);
        end
        f0 = ferr_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom));
        ps2_data = 1'b1;
        tick(TMO + 10);
        n_tests++;
        if (ferr_cnt - f0 != 1 || level !== 3'd0) begin
            n_fail++; $display("FAIL timeout_err: ferr=%0d level=%0d expected 1 0", ferr_cnt - f0, level);
        end
        f0 = ferr_cnt; p0 = perr_cnt;
        send_frame(8'h5A, 1'b0, 1'b1);
        n_tests++;
        if ({data, level} !== {8'h5A, 3'd1} || ferr_cnt != f0 || perr_cnt != p0) begin
            n_fail++; $display("FAIL after_timeout: data=%h level=%0d expected 5a 1", data, level);
        end
        pop1();
    endtask

    task automatic test_full();
        logic [7:0] seq [5];
        seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        model_q.delete(); model_ovf = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_frame(seq[i], 1'b0, 1'b1);
            model_push(seq[i]);
        end
        n_tests++;
        if (level !== 3'(model_q.size()) || overflow !== model_ovf) begin
            n_fail++; $display("FAIL full_level: level=%0d ovf=%b expected %0d %b", level, overflow, model_q.size(), model_ovf);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (data !== model_q[0]) begin
                n_fail++; $display("FAIL full_order%0d: data=%h expected %h", i, data, model_q[0]);
            end
            pop1();
            void'(model_q.pop_front());
        end
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        model_ovf = 1'b0;
        n_tests++;
        if (overflow !== 1'b0 || level !== 3'd0) begin
            n_fail++; $display("FAIL ovf_clr: ovf=%b level=%0d expected 0 0", overflow, level);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b0, 1'b1);
            model_push(b);
        end
        b = 8'($urandom);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~^b);
        ps2_data = 1'b1;
        tick(4);
        ps2_clk = 1'b0;
        tick(PUSH_LAT - 1);
        nextdata_n = 1'b0;
        tick(1);
        nextdata_n = 1'b1;
        void'(model_q.pop_front());
        model_push(b);
        n_tests++;
        if (level !== 3'(model_q.size()) || overflow !== 1'b0 || data !== model_q[0]) begin
            n_fail++; $display("FAIL full_push_pop: level=%0d ovf=%b data=%h expected %0d 0 %h", level, overflow, data, model_q.size(), model_q[0]);
        end
        tick(8 - PUSH_LAT);
        ps2_clk = 1'b1;
        tick(8);
        for (int i = 0; i < DEPTH; i++) begin
            n_tests++;
            if (data !== model_q[0]) begin
                n_fail++; $display("FAIL burst_pop%0d: data=%h expected %h", i, data, model_q[0]);
            end
            nextdata_n = 1'b0;
            tick(1);
            void'(model_q.pop_front());
        end
        nextdata_n = 1'b1;
        n_tests++;
        if (level !== 3'd0 || data !== 8'h00) begin
            n_fail++; $display("FAIL burst_empty: level=%0d data=%h expected 0 00", level, data);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] b;
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b0, 1'b1);
            model_push(b);
        end
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b0, 1'b1);
            model_push(b);
            n_tests++;
            if (data !== model_q[0] || level !== 3'(model_q.size())) begin
                n_fail++; $display("FAIL wrap%0d: data=%h level=%0d expected %h %0d", i, data, level, model_q[0], model_q.size());
            end
            pop1();
            void'(model_q.pop_front());
        end
        while (model_q.size() > 0) begin
            n_tests++;
            if (data !== model_q[0]) begin
                n_fail++; $display("FAIL wrap_drain: data=%h expected %h", data, model_q[0]);
            end
            pop1();
            void'(model_q.pop_front());
        end
    endtask

    task automatic test_glitch();
        int p0, f0;
        logic [7:0] b;
        p0 = perr_cnt; f0 = ferr_cnt;
        ps2_data = 1'b0;
        ps2_clk = 1'b0;
        tick(FL - 1);
        ps2_clk = 1'b1;
        tick(10);
        ps2_data = 1'b1;
        tick(10);
        b = 8'($urandom);
        send_frame(b, 1'b0, 1'b1);
        n_tests++;
        if (data !== b || level !== 3'd1 || perr_cnt != p0 || ferr_cnt != f0) begin
            n_fail++; $display("FAIL glitch: data=%h level=%0d errs=%0d expected %h 1 0", data, level, perr_cnt - p0 + ferr_cnt - f0, b);
        end
        pop1();
    endtask

    task automatic test_reset_mid_frame();
        int p0, f0;
        logic [7:0] b;
        send_frame(8'($urandom), 1'b0, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        ps2_data = 1'b1;
        p0 = perr_cnt; f0 = ferr_cnt;
        rst = 1'b0;
        tick(2);
        n_tests++;
        if ({data, ready, level, overflow, parity_err, frame_err} !== 15'h0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got %h expected 0", {data, ready, level, overflow, parity_err, frame_err});
        end
        rst = 1'b1;
        model_q.delete(); model_ovf = 1'b0;
        tick(TMO + 10);
        n_tests++;
        if (perr_cnt != p0 || ferr_cnt != f0) begin
            n_fail++; $display("FAIL mid_reset_pulse: errs=%0d expected 0", perr_cnt - p0 + ferr_cnt - f0);
        end
        b = 8'($urandom);
        send_frame(b, 1'b0, 1'b1);
        n_tests++;
        if (data !== b || level !== 3'd1) begin
            n_fail++; $display("FAIL mid_reset_rx: data=%h level=%0d expected %h 1", data, level, b);
        end
        pop1();
    endtask

    task automatic test_random();
        logic [7:0] b;
        model_q.delete(); model_ovf = 1'b0;
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b0, 1'b1);
            model_push(b);
            if ($urandom_range(0, 2) == 0) begin
                n_tests++;
                if (data !== model_q[0]) begin
                    n_fail++; $display("FAIL random_pop%0d: data=%h expected %h", i, data, model_q[0]);
                end
                pop1();
                void'(model_q.pop_front());
            end
        end
        n_tests++;
        if (level !== 3'(model_q.size()) || overflow !== model_ovf) begin
            n_fail++; $display("FAIL random_state: level=%0d ovf=%b expected %0d %b", level, overflow, model_q.size(), model_ovf);
        end
        while (model_q.size() > 0) begin
            n_tests++;
            if (data !== model_q[0]) begin
                n_fail++; $display("FAIL random_drain: data=%h expected %h", data, model_q[0]);
            end
            pop1();
            void'(model_q.pop_front());
        end
    endtask

    initial begin
        tick(2);
        test_reset();
        test_single_byte();
        test_errors();
        test_full();
        test_back_to_back();
        test_wrap();
        test_glitch();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
